// File: rtl/cla_seq_pkg.sv
// Shared types and widths for the multi-precision CLA add/sub sequencer.
package cla_seq_pkg;
  localparam int unsigned ADD_W = 16;

  typedef enum logic [1:0] {IDLE, RUN, DONE} seq_state_e;

  typedef logic [ADD_W-1:0] word_t;
endpackage

// File: rtl/cla_seq_opreg.sv
// Operand store for the sequencer: latches A and B (B inverted for subtract)
// on load and presents the word selected by idx.
module cla_seq_opreg
  import cla_seq_pkg::*;
#(
  parameter int unsigned WORDS = 4,
  localparam int unsigned IDX_W = $clog2(WORDS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load,
  input  logic [WORDS*ADD_W-1:0] in_a,
  input  logic [WORDS*ADD_W-1:0] in_b,
  input  logic                   in_sub,
  input  logic [IDX_W-1:0]       idx,
  output word_t                  word_a,
  output word_t                  word_b
);

  word_t a_q [WORDS];
  word_t b_q [WORDS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '{default: '0};
      b_q <= '{default: '0};
    end else if (load) begin
      for (int unsigned w = 0; w < WORDS; w++) begin
        a_q[w] <= in_a[w*ADD_W +: ADD_W];
        b_q[w] <= in_sub ? ~in_b[w*ADD_W +: ADD_W] : in_b[w*ADD_W +: ADD_W];
      end
    end
  end

  assign word_a = a_q[idx];
  assign word_b = b_q[idx];

endmodule

// File: rtl/cla_mp_add_seq.sv
// Multi-precision add/sub sequencer driving an external 16-bit CLA, LSW first.
// Optional back-to-back accept on result handoff: define CLA_SEQ_B2B_EN.
module cla_mp_add_seq
  import cla_seq_pkg::*;
#(
  parameter int unsigned WORDS = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WORDS*ADD_W-1:0] in_a,
  input  logic [WORDS*ADD_W-1:0] in_b,
  input  logic                   in_sub,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WORDS*ADD_W-1:0] out_sum,
  output logic                   out_cout,
  output logic                   out_ovf,
  output logic [ADD_W-1:0]       add_a,
  output logic [ADD_W-1:0]       add_b,
  output logic                   add_cin,
  input  logic [ADD_W-1:0]       add_sum,
  input  logic                   add_cout
);

  localparam int unsigned IDX_W = $clog2(WORDS);

  seq_state_e       state, state_n;
  logic [IDX_W-1:0] idx;
  logic             carry_q, cout_q, ovf_q;
  word_t            sum_q [WORDS];
  word_t            word_a, word_b;
  logic             accept, last;

  cla_seq_opreg #(.WORDS(WORDS)) u_opreg (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (accept),
    .in_a   (in_a),
    .in_b   (in_b),
    .in_sub (in_sub),
    .idx    (idx),
    .word_a (word_a),
    .word_b (word_b)
  );

  assign last = (idx == IDX_W'(WORDS-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    add_a     = '0;
    add_b     = '0;
    add_cin   = 1'b0;
    case (state)
      IDLE: in_ready = 1'b1;
      RUN: begin
        add_a   = word_a;
        add_b   = word_b;
        add_cin = carry_q;
        if (last) state_n = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
`ifdef CLA_SEQ_B2B_EN
        in_ready  = out_ready;
`endif
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    accept = in_valid && in_ready;
    // An accept in DONE (back-to-back build) skips IDLE entirely.
    if (accept) state_n = RUN;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q   <= '{default: '0};
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      idx     <= '0;
    end else if (accept) begin
      sum_q   <= '{default: '0};
      carry_q <= in_sub;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      idx     <= '0;
    end else if (state == RUN) begin
      sum_q[idx] <= add_sum;
      carry_q    <= add_cout;
      if (last) begin
        cout_q <= add_cout;
        ovf_q  <= (word_a[ADD_W-1] == word_b[ADD_W-1]) &&
                  (add_sum[ADD_W-1] != word_a[ADD_W-1]);
        idx    <= '0;
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

  always_comb begin
    out_sum = '0;
    for (int unsigned w = 0; w < WORDS; w++) out_sum[w*ADD_W +: ADD_W] = sum_q[w];
  end

  assign out_cout = cout_q;
  assign out_ovf  = ovf_q;

endmodule

// File: tb/tb_cla_mp_add_seq.sv
// Directed self-checking bench for cla_mp_add_seq (WORDS=4); models the external 16-bit adder.
module tb_cla_mp_add_seq;
  localparam int unsigned WORDS = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_sub;
  logic [63:0] in_a, in_b;
  logic        out_valid, out_ready, out_cout, out_ovf;
  logic [63:0] out_sum;
  logic [15:0] add_a, add_b, add_sum;
  logic        add_cin, add_cout;

  int errors = 0;
  int checks = 0;

  cla_mp_add_seq #(.WORDS(WORDS)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout)
  );

  always #5 clk = ~clk;

  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {16'd0, add_cin};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Presents a request, waits for in_ready, returns #1 after the accept edge,
  // then scrambles the inputs to confirm they are not re-sampled.
  task automatic send(input logic [63:0] a, input logic [63:0] b, input logic sub);
    int n = 0;
    in_a = a; in_b = b; in_sub = sub; in_valid = 1'b1;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check("accept_timeout", 64'(n < 20), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_a = ~a; in_b = ~b; in_sub = ~sub;
  endtask

  task automatic collect(output logic [3:0] cins, output int lat);
    cins = '0;
    lat  = 0;
    while (!out_valid && lat < 20) begin
      if (lat < 4) cins[lat] = add_cin;
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic handoff();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  logic [3:0] cins;
  int         lat;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_sub = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
    #2;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_sum", out_sum, 64'd0);
    check("rst_add_a", 64'(add_a), 64'd0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: carry ripples out of word 0 into word 1
    send(64'h0000_0000_0000_FFFF, 64'd1, 1'b0);
    collect(cins, lat);
    check("t1_latency", 64'(lat), 64'd4);
    check("t1_cin_seq", 64'(cins), 64'b0010);
    check("t1_sum", out_sum, 64'h0000_0000_0001_0000);
    check("t1_cout", 64'(out_cout), 64'd0);
    check("t1_ovf", 64'(out_ovf), 64'd0);
    check("t1_add_a_idle", 64'(add_a), 64'd0);
    check("t1_add_cin_idle", 64'(add_cin), 64'd0);
    handoff();

    // 2: full wrap-around
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
    collect(cins, lat);
    check("t2_sum", out_sum, 64'd0);
    check("t2_cout", 64'(out_cout), 64'd1);
    check("t2_ovf", 64'(out_ovf), 64'd0);
    handoff();

    // 3: signed overflow at the top word
    send(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
    collect(cins, lat);
    check("t3_sum", out_sum, 64'h8000_0000_0000_0000);
    check("t3_cout", 64'(out_cout), 64'd0);
    check("t3_ovf", 64'(out_ovf), 64'd1);
    handoff();

    // 4: subtract with borrow
    send(64'd5, 64'd7, 1'b1);
    collect(cins, lat);
    check("t4_cin_seq", 64'(cins), 64'b0001);
    check("t4_sum", out_sum, 64'hFFFF_FFFF_FFFF_FFFE);
    check("t4_cout", 64'(out_cout), 64'd0);
    check("t4_ovf", 64'(out_ovf), 64'd0);

    // 5: back-pressure keeps the result stable
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("t5_hold_valid", 64'(out_valid), 64'd1);
      check("t5_hold_sum", out_sum, 64'hFFFF_FFFF_FFFF_FFFE);
      check("t5_hold_in_ready", 64'(in_ready), 64'd0);
    end
`ifdef CLA_SEQ_B2B_EN
    in_a = 64'h0001_0002_0003_0004; in_b = 64'h0010_0020_0030_0040; in_sub = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    #0;
    check("t5_b2b_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0; in_a = '0;
    collect(cins, lat);
    check("t5_b2b_latency", 64'(lat), 64'd4);
    check("t5_b2b_sum", out_sum, 64'h0011_0022_0033_0044);
    handoff();
`else
    handoff();
    check("t5_idle_out_valid", 64'(out_valid), 64'd0);
    check("t5_idle_in_ready", 64'(in_ready), 64'd1);
`endif

    // 6: asynchronous reset in the middle of RUN
    send(64'h4444_3333_2222_1111, 64'h0000_0000_0000_0000, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("t6_idx2_add_a", 64'(add_a), 64'h3333);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_in_ready", 64'(in_ready), 64'd1);
    check("t6_rst_out_valid", 64'(out_valid), 64'd0);
    check("t6_rst_out_sum", out_sum, 64'd0);
    check("t6_rst_flags", 64'({out_cout, out_ovf}), 64'd0);
    check("t6_rst_add", 64'({add_a, add_b, add_cin}), 64'd0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    send(64'd3, 64'd4, 1'b0);
    collect(cins, lat);
    check("t6_next_latency", 64'(lat), 64'd4);
    check("t6_next_sum", out_sum, 64'd7);
    check("t6_next_flags", 64'({out_cout, out_ovf}), 64'd0);
    handoff();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
